// File: rtl/riscv_pkg.sv
// Shared RV32 constants and fetch-side types.
//   XLEN, NOP_INSTR, RESET_PC_DEFAULT : machine width, bubble encoding, boot PC
//   OP_*                              : base opcode constants (shared with the main decoder)
//   fetch_entry_t                     : buffered {instr, pc} pair
//   dec_src_e                         : what the decode register loads on an edge
//   pc_next()                         : sequential PC, wraps modulo 2^XLEN
package riscv_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      DSRC_BUBBLE,
      DSRC_HOLD,
      DSRC_QUEUE,
      DSRC_BYPASS
   } dec_src_e;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Parameterised-depth synchronous FIFO with push/pop/clear.
//   clk, reset         : clock, asynchronous active-high reset
//   push, push_data    : write one entry (dropped only if full and not popping)
//   pop                : retire the head entry (ignored when empty)
//   clear              : empty the FIFO, overrides push/pop
//   head_data, count   : current head entry and occupancy
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches under a credit limit,
// pairs in-order responses with their PCs, buffers them and feeds the decode
// register. Redirects flush the buffer and drop responses still in flight.
//   clk, reset                       : clock, asynchronous active-high reset
//   imem_req/addr/gnt                : request channel (req and addr hold until gnt)
//   imem_rvalid/rdata                : in-order response channel
//   StallD, FlushD                   : hold / bubble the decode register
//   PCSrcE, PCTargetE                : redirect from execute
//   InstrD, PCD, PCPlus4D, ValidD    : decode register outputs
//   BubbleCnt (FETCH_PERF_EN only)   : saturating count of bubbles entering decode
//
// Decode register source, chosen each edge:
//   dec_src      | meaning
//   DSRC_BUBBLE  | redirect, flush, or nothing available: load NOP, ValidD=0
//   DSRC_HOLD    | StallD: keep the current instruction
//   DSRC_QUEUE   | load the oldest buffered response
//   DSRC_BYPASS  | queue empty: load this cycle's response directly
module fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] BubbleCnt
`endif
);

   localparam int CW = $clog2(MAX_OUTST + 1);

   logic [31:0]   pcf_q, pcf_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pcd_q, pcd_d;
   logic          valid_q, valid_d;
   logic [CW-1:0] disc_q, disc_d;

   logic [CW-1:0] ost_cnt, rq_cnt;
   logic [31:0]   ost_pc;
   logic [31:0]   target_aligned;
   fetch_entry_t  rq_head, rq_push_data;
   logic [CW:0]   in_use;
   logic          fire, resp_keep, rq_push, rq_pop;
   dec_src_e      dec_src;

   // Requests outstanding plus responses buffered may never exceed the queue
   // depth, so every response that arrives always has a slot.
   assign in_use    = {1'b0, ost_cnt} + {1'b0, rq_cnt};
   assign imem_req  = ~reset & ~PCSrcE & (in_use < (CW + 1)'(MAX_OUTST));
   assign imem_addr = pcf_q;
   assign fire      = imem_req & imem_gnt;

   // Stale responses (pre-redirect) are dropped; so is one landing in the redirect cycle.
   assign resp_keep      = imem_rvalid & ~PCSrcE & (disc_q == '0);
   assign target_aligned = PCTargetE & ~32'h3;

   always_comb begin
      if (PCSrcE || FlushD)   dec_src = DSRC_BUBBLE;
      else if (StallD)        dec_src = DSRC_HOLD;
      else if (rq_cnt != '0)  dec_src = DSRC_QUEUE;
      else if (resp_keep)     dec_src = DSRC_BYPASS;
      else                    dec_src = DSRC_BUBBLE;
   end

   assign rq_pop       = (dec_src == DSRC_QUEUE);
   assign rq_push      = resp_keep && (dec_src != DSRC_BYPASS);
   assign rq_push_data = '{instr: imem_rdata, pc: ost_pc};

   fetch_queue #(.DEPTH(MAX_OUTST), .WIDTH(32)) u_ost_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fire),
      .push_data (pcf_q),
      .pop       (imem_rvalid),
      .clear     (1'b0),
      .head_data (ost_pc),
      .count     (ost_cnt)
   );

   fetch_queue #(.DEPTH(MAX_OUTST), .WIDTH($bits(fetch_entry_t))) u_resp_queue (
      .clk       (clk),
      .reset     (reset),
      .push      (rq_push),
      .push_data (rq_push_data),
      .pop       (rq_pop),
      .clear     (PCSrcE),
      .head_data (rq_head),
      .count     (rq_cnt)
   );

   always_comb begin
      pcf_d = pcf_q;
      if (PCSrcE)    pcf_d = target_aligned;
      else if (fire) pcf_d = pc_next(pcf_q);

      // The PC FIFO is never cleared; everything left in it after a redirect is stale.
      disc_d = disc_q;
      if (PCSrcE)
         disc_d = ost_cnt - CW'(imem_rvalid && (ost_cnt != '0));
      else if (imem_rvalid && (disc_q != '0))
         disc_d = disc_q - CW'(1);

      instr_d = instr_q;
      pcd_d   = pcd_q;
      valid_d = valid_q;
      case (dec_src)
         DSRC_QUEUE: begin
            instr_d = rq_head.instr;
            pcd_d   = rq_head.pc;
            valid_d = 1'b1;
         end
         DSRC_BYPASS: begin
            instr_d = imem_rdata;
            pcd_d   = ost_pc;
            valid_d = 1'b1;
         end
         DSRC_BUBBLE: begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pcf_q   <= RESET_PC;
         instr_q <= NOP_INSTR;
         pcd_q   <= RESET_PC;
         valid_q <= 1'b0;
         disc_q  <= '0;
      end else begin
         pcf_q   <= pcf_d;
         instr_q <= instr_d;
         pcd_q   <= pcd_d;
         valid_q <= valid_d;
         disc_q  <= disc_d;
      end
   end

   assign InstrD   = instr_q;
   assign PCD      = pcd_q;
   assign PCPlus4D = pc_next(pcd_q);
   assign ValidD   = valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (!valid_d && !StallD && (bubble_cnt_q != 32'hFFFF_FFFF))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) bubble_cnt_q <= '0;
      else       bubble_cnt_q <= bubble_cnt_d;
   end

   assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a directed vector table (zero-wait stream, stall
// back-pressure, redirect with stale responses, flush+stall, PC wrap with
// delayed grant), a mid-burst reset, then randomized traffic checked against
// a queue-based reference model.
module tb_fetch_stage;
   import riscv_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          MAXO   = 2;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        StallD, FlushD, PCSrcE;
   logic [31:0] PCTargetE;
   logic [31:0] InstrD, PCD, PCPlus4D;
   logic        ValidD;
`ifdef FETCH_PERF_EN
   logic [31:0] BubbleCnt;
   logic [31:0] m_bub;
`endif

   fetch_stage #(.RESET_PC(RST_PC), .MAX_OUTST(MAXO)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .ValidD      (ValidD)
`ifdef FETCH_PERF_EN
      ,
      .BubbleCnt   (BubbleCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem_pend [$];

   typedef struct {
      logic        st, fl, ps;
      logic [31:0] tg;
      logic        gn, re;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pcd;
   } vec_t;
   vec_t tbl [$];

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic [31:0] m_pcf, m_instr, m_pc;
   logic        m_valid;
   int          m_disc;
   logic [31:0] m_pend [$];
   ent_t        m_buf [$];

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, fl, ps, input logic [31:0] tg, input logic gn, re,
                      input logic req, input logic [31:0] addr, input logic v, input logic [31:0] pcd);
      vec_t r;
      r.st = st; r.fl = fl; r.ps = ps; r.tg = tg; r.gn = gn; r.re = re;
      r.exp_req = req; r.exp_addr = addr; r.exp_valid = v; r.exp_pcd = pcd;
      tbl.push_back(r);
   endtask

   // Memory answers in order, from its own record of accepted requests.
   task automatic drive(input logic st, fl, ps, input logic [31:0] tg, input logic gn, re);
      StallD = st; FlushD = fl; PCSrcE = ps; PCTargetE = tg; imem_gnt = gn;
      if (re && (mem_pend.size() > 0)) begin
         imem_rvalid = 1'b1;
         imem_rdata  = imem_word(mem_pend[0]);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
   endtask

   task automatic edge_step();
      logic        f, rv;
      logic [31:0] a;
      f  = imem_req & imem_gnt;
      rv = imem_rvalid;
      a  = imem_addr;
      @(posedge clk);
      if (rv && (mem_pend.size() > 0)) void'(mem_pend.pop_front());
      if (f) mem_pend.push_back(a);
      #1;
   endtask

   task automatic check_dec(input string tag, input logic v, input logic [31:0] pcd);
      check({tag, "_valid"}, {31'd0, ValidD}, {31'd0, v});
      check({tag, "_pcd"}, PCD, pcd);
      check({tag, "_pcp4"}, PCPlus4D, pcd + 32'd4);
      check({tag, "_instr"}, InstrD, v ? imem_word(pcd) : NOP_INSTR);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
      check({tag, "_addr"}, imem_addr, RST_PC);
      check({tag, "_instr"}, InstrD, NOP_INSTR);
      check({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
      check({tag, "_pcd"}, PCD, RST_PC);
      check({tag, "_pcp4"}, PCPlus4D, RST_PC + 32'd4);
`ifdef FETCH_PERF_EN
      check({tag, "_bubcnt"}, BubbleCnt, 32'd0);
`endif
   endtask

   task automatic model_reset();
      m_pcf = RST_PC; m_instr = NOP_INSTR; m_pc = RST_PC; m_valid = 1'b0; m_disc = 0;
      m_pend.delete(); m_buf.delete();
`ifdef FETCH_PERF_EN
      m_bub = 32'd0;
`endif
   endtask

   task automatic model_cycle(input logic st, fl, ps, input logic [31:0] tg, input logic gn, re);
      logic        exp_req, keep, byp;
      logic [31:0] rpc, rdat;
      ent_t        e;
      drive(st, fl, ps, tg, gn, re);
      #1;
      exp_req = !ps && ((m_pend.size() + m_buf.size()) < MAXO);
      check("rnd_req", {31'd0, imem_req}, {31'd0, exp_req});
      check("rnd_addr", imem_addr, m_pcf);
      keep = 1'b0;
      rpc  = 32'd0;
      rdat = imem_rdata;
      if (imem_rvalid && (m_pend.size() > 0)) begin
         rpc = m_pend.pop_front();
         if (ps)              keep = 1'b0;
         else if (m_disc > 0) m_disc--;
         else                 keep = 1'b1;
      end
      if (ps) begin
         m_disc = m_pend.size();
         m_buf.delete();
      end
      if (exp_req && gn) m_pend.push_back(m_pcf);
      byp = 1'b0;
      if (ps || fl) begin
         m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (st) begin
         byp = 1'b0;
      end else if (m_buf.size() > 0) begin
         e = m_buf.pop_front();
         m_instr = e.instr; m_pc = e.pc; m_valid = 1'b1;
      end else if (keep) begin
         m_instr = rdat; m_pc = rpc; m_valid = 1'b1; byp = 1'b1;
      end else begin
         m_instr = NOP_INSTR; m_valid = 1'b0;
      end
      if (keep && !byp) m_buf.push_back('{rdat, rpc});
`ifdef FETCH_PERF_EN
      if (!m_valid && !st && (m_bub != 32'hFFFF_FFFF)) m_bub = m_bub + 32'd1;
`endif
      if (ps)                 m_pcf = tg & ~32'h3;
      else if (exp_req && gn) m_pcf = m_pcf + 32'd4;
      edge_step();
      check("rnd_instr", InstrD, m_instr);
      check("rnd_pcd", PCD, m_pc);
      check("rnd_pcp4", PCPlus4D, m_pc + 32'd4);
      check("rnd_valid", {31'd0, ValidD}, {31'd0, m_valid});
`ifdef FETCH_PERF_EN
      check("rnd_bubcnt", BubbleCnt, m_bub);
`endif
   endtask

   initial begin
      //   st fl ps target          gn re | req addr            v pcd
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0000,  0, 32'h0000_0000);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0004,  1, 32'h0000_0000);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0008,  1, 32'h0000_0004);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_000C,  1, 32'h0000_0008);
      add(1, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0010,  1, 32'h0000_0008);
      add(1, 0, 0, 32'h0,          1, 1,  0, 32'h0000_0014,  1, 32'h0000_0008);
      add(1, 0, 0, 32'h0,          1, 1,  0, 32'h0000_0014,  1, 32'h0000_0008);
      add(0, 0, 0, 32'h0,          1, 1,  0, 32'h0000_0014,  1, 32'h0000_000C);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0014,  1, 32'h0000_0010);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0018,  1, 32'h0000_0014);
      add(0, 0, 0, 32'h0,          1, 0,  1, 32'h0000_001C,  0, 32'h0000_0014);
      add(0, 0, 1, 32'h0000_0102,  1, 0,  0, 32'h0000_0020,  0, 32'h0000_0014);
      add(0, 0, 0, 32'h0,          1, 1,  0, 32'h0000_0100,  0, 32'h0000_0014);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0100,  0, 32'h0000_0014);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0104,  1, 32'h0000_0100);
      add(1, 1, 0, 32'h0,          1, 1,  1, 32'h0000_0108,  0, 32'h0000_0100);
      add(0, 0, 0, 32'h0,          1, 1,  0, 32'h0000_010C,  1, 32'h0000_0104);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_010C,  1, 32'h0000_0108);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0110,  1, 32'h0000_010C);
      add(0, 0, 1, 32'hFFFF_FFFF,  1, 0,  0, 32'h0000_0114,  0, 32'h0000_010C);
      add(0, 0, 0, 32'h0,          0, 1,  1, 32'hFFFF_FFFC,  0, 32'h0000_010C);
      add(0, 0, 0, 32'h0,          0, 1,  1, 32'hFFFF_FFFC,  0, 32'h0000_010C);
      add(0, 0, 0, 32'h0,          0, 1,  1, 32'hFFFF_FFFC,  0, 32'h0000_010C);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'hFFFF_FFFC,  0, 32'h0000_010C);
      add(0, 0, 0, 32'h0,          0, 1,  1, 32'h0000_0000,  1, 32'hFFFF_FFFC);
      add(0, 0, 0, 32'h0,          1, 1,  1, 32'h0000_0000,  0, 32'hFFFF_FFFC);

      reset = 1'b1;
      drive(0, 0, 0, 32'h0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].fl, tbl[i].ps, tbl[i].tg, tbl[i].gn, tbl[i].re);
         #1;
         check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].exp_req});
         check($sformatf("v%0d_addr", i), imem_addr, tbl[i].exp_addr);
         edge_step();
         check_dec($sformatf("v%0d", i), tbl[i].exp_valid, tbl[i].exp_pcd);
      end

      // Reset in the middle of a streaming burst; memory is reset with the core.
      repeat (3) begin
         drive(0, 0, 0, 32'h0, 1, 1);
         #1;
         edge_step();
      end
      reset = 1'b1;
      mem_pend.delete();
      drive(0, 0, 0, 32'h0, 0, 0);
      #1;
      check_reset_vals("midrst");
      @(posedge clk);
      #1;
      check_reset_vals("midrst_hold");
      reset = 1'b0;

      model_reset();
      model_cycle(0, 0, 0, 32'h0, 1, 1);
      model_cycle(0, 0, 0, 32'h0, 1, 1);
      model_cycle(0, 0, 0, 32'h0, 1, 1);
      for (int n = 0; n < 3000; n++) begin
         model_cycle($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0,
                     $urandom_range(0, 19) == 0,
                     $urandom,
                     $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 7);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
